openmips_min_sopc: RTL and testbench

- Minimal MIPS32 system-on-chip for simulation: a 5-stage in-order pipeline (IF, ID, EX, MEM, WB) with a private instruction ROM, a 32x32 GPR file and HI/LO registers.
- Supports a reduced integer subset aimed at register-move instructions.
- No external buses: the bench loads the ROM and observes internal state through hierarchical paths.

---
 rtl/openmips_min_sopc.sv | 218 +++++++++++++++++++++
 tb/tb_openmips_min_sopc.sv | 107 ++++++++++
 2 files changed

// File: rtl/openmips_min_sopc.sv
// Minimal MIPS32 SoC: 5-stage in-order core (IF/ID/EX/MEM/WB) with private
// instruction ROM, 32x32 GPR file and HI/LO pair; register-move subset only.

module inst_rom #(
    parameter int ROM_DEPTH = 1024,
    parameter int ROM_AW    = 10
) (
    input  logic              ce_i,
    input  logic [ROM_AW-1:0] addr_i,
    output logic [31:0]       inst_o
);
    logic [31:0] inst_mem [0:ROM_DEPTH-1];

    assign inst_o = ce_i ? inst_mem[addr_i] : '0;
endmodule

module regfile (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    output logic [31:0] rdata1_o,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata2_o
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk_i) begin
        if (we_i && waddr_i != '0) regs[waddr_i] <= wdata_i;
    end

    // Same-cycle write data bypasses the array so WB never needs a forward path.
    assign rdata1_o = (raddr1_i == '0) ? '0 :
                      (we_i && raddr1_i == waddr_i) ? wdata_i : regs[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 :
                      (we_i && raddr2_i == waddr_i) ? wdata_i : regs[raddr2_i];
endmodule

module hilo_reg (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_hi_i,
    input  logic        we_lo_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hi_o <= '0;
            lo_o <= '0;
        end else begin
            if (we_hi_i) hi_o <= hi_i;
            if (we_lo_i) lo_o <= lo_i;
        end
    end
endmodule

module openmips #(
    parameter int ROM_DEPTH = 1024,
    parameter int ROM_AW    = 10
) (
    input logic clk_i,
    input logic rst_i
);
    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_SLL  = 3'd2;
    localparam logic [2:0] OP_MFHI = 3'd3;
    localparam logic [2:0] OP_MFLO = 3'd4;
    localparam logic [2:0] OP_MTHI = 3'd5;
    localparam logic [2:0] OP_MTLO = 3'd6;

    typedef struct packed {
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        whi;
        logic        wlo;
        logic [31:0] hl;
    } res_t;

    logic        ce_q;
    logic [31:0] pc_q, if_inst_q, rom_inst;
    logic [2:0]  ex_op_q, ex_op_d;
    logic [31:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
    logic [4:0]  ex_wd_q, ex_wd_d;
    logic        ex_wreg_q, ex_wreg_d;
    res_t        ex_res, mem_q, wb_q;
    logic [31:0] rf_rdata1, rf_rdata2, rs_val, rt_val;
    logic [31:0] hi_w, lo_w, hi_fwd, lo_fwd;

    inst_rom #(.ROM_DEPTH(ROM_DEPTH), .ROM_AW(ROM_AW)) inst_rom0 (
        .ce_i(ce_q), .addr_i(pc_q[ROM_AW+1:2]), .inst_o(rom_inst)
    );

    regfile regfile1 (
        .clk_i(clk_i), .we_i(wb_q.wreg), .waddr_i(wb_q.wd), .wdata_i(wb_q.wdata),
        .raddr1_i(if_inst_q[25:21]), .rdata1_o(rf_rdata1),
        .raddr2_i(if_inst_q[20:16]), .rdata2_o(rf_rdata2)
    );

    hilo_reg hilo_reg0 (
        .clk_i(clk_i), .rst_i(rst_i), .we_hi_i(wb_q.whi), .we_lo_i(wb_q.wlo),
        .hi_i(wb_q.hl), .lo_i(wb_q.hl), .hi_o(hi_w), .lo_o(lo_w)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ce_q      <= 1'b0;
            pc_q      <= '0;
            if_inst_q <= '0;
        end else begin
            ce_q      <= 1'b1;
            pc_q      <= ce_q ? pc_q + 32'd4 : '0;
            if_inst_q <= rom_inst;
        end
    end

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf,
                                        input res_t ex, input res_t mem);
        if (a != '0 && ex.wreg && ex.wd == a) return ex.wdata;
        if (a != '0 && mem.wreg && mem.wd == a) return mem.wdata;
        return rf;
    endfunction

    assign rs_val = fwd(if_inst_q[25:21], rf_rdata1, ex_res, mem_q);
    assign rt_val = fwd(if_inst_q[20:16], rf_rdata2, ex_res, mem_q);

    always_comb begin
        ex_op_d   = OP_NOP;
        ex_a_d    = '0;
        ex_b_d    = '0;
        ex_wd_d   = '0;
        ex_wreg_d = 1'b0;
        case (if_inst_q[31:26])
            6'h0F: begin
                ex_op_d = OP_OR; ex_b_d = {if_inst_q[15:0], 16'h0000};
                ex_wd_d = if_inst_q[20:16]; ex_wreg_d = 1'b1;
            end
            6'h0D: begin
                ex_op_d = OP_OR; ex_a_d = rs_val; ex_b_d = {16'h0000, if_inst_q[15:0]};
                ex_wd_d = if_inst_q[20:16]; ex_wreg_d = 1'b1;
            end
            6'h00: begin
                ex_wd_d = if_inst_q[15:11];
                case (if_inst_q[5:0])
                    6'h00: begin
                        ex_op_d = OP_SLL; ex_a_d = {27'd0, if_inst_q[10:6]};
                        ex_b_d = rt_val; ex_wreg_d = 1'b1;
                    end
                    // Move condition is resolved here so it sees the forwarded rt.
                    6'h0A: begin ex_op_d = OP_OR; ex_a_d = rs_val; ex_wreg_d = (rt_val == '0); end
                    6'h0B: begin ex_op_d = OP_OR; ex_a_d = rs_val; ex_wreg_d = (rt_val != '0); end
                    6'h10: begin ex_op_d = OP_MFHI; ex_wreg_d = 1'b1; end
                    6'h12: begin ex_op_d = OP_MFLO; ex_wreg_d = 1'b1; end
                    6'h11: begin ex_op_d = OP_MTHI; ex_a_d = rs_val; end
                    6'h13: begin ex_op_d = OP_MTLO; ex_a_d = rs_val; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_op_q <= OP_NOP; ex_a_q <= '0; ex_b_q <= '0; ex_wd_q <= '0; ex_wreg_q <= 1'b0;
        end else begin
            ex_op_q <= ex_op_d; ex_a_q <= ex_a_d; ex_b_q <= ex_b_d;
            ex_wd_q <= ex_wd_d; ex_wreg_q <= ex_wreg_d;
        end
    end

    assign hi_fwd = mem_q.whi ? mem_q.hl : (wb_q.whi ? wb_q.hl : hi_w);
    assign lo_fwd = mem_q.wlo ? mem_q.hl : (wb_q.wlo ? wb_q.hl : lo_w);

    always_comb begin
        ex_res      = '0;
        ex_res.wreg = ex_wreg_q;
        ex_res.wd   = ex_wd_q;
        ex_res.whi  = (ex_op_q == OP_MTHI);
        ex_res.wlo  = (ex_op_q == OP_MTLO);
        ex_res.hl   = ex_a_q;
        case (ex_op_q)
            OP_OR:   ex_res.wdata = ex_a_q | ex_b_q;
            OP_SLL:  ex_res.wdata = ex_b_q << ex_a_q[4:0];
            OP_MFHI: ex_res.wdata = hi_fwd;
            OP_MFLO: ex_res.wdata = lo_fwd;
            default: ;
        endcase
    end

    // No memory ops in this subset, so MEM is a plain pipeline register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            mem_q <= ex_res;
            wb_q  <= mem_q;
        end
    end
endmodule

module openmips_min_sopc #(
    parameter int ROM_DEPTH = 1024,
    parameter int ROM_AW    = 10
) (
    input logic clk,
    input logic rst
);
    openmips #(.ROM_DEPTH(ROM_DEPTH), .ROM_AW(ROM_AW)) openmips0 (
        .clk_i(clk), .rst_i(rst)
    );
endmodule

// File: tb/tb_openmips_min_sopc.sv
// Directed program test of the minimal MIPS SoC: lui, movz/movn, mthi/mfhi,
// mtlo/mflo with forwarding, plus asynchronous mid-program reset.

module tb_openmips_min_sopc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    openmips_min_sopc #(.ROM_DEPTH(1024), .ROM_AW(10)) dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    logic [31:0] prog [16] = '{
        32'h3C010000, 32'h3C02FFFF, 32'h3C030505, 32'h3C040000,
        32'h0041200A, 32'h0061200B, 32'h0062200B, 32'h0043200A,
        32'h00000011, 32'h00400011, 32'h00600011, 32'h00002010,
        32'h00600013, 32'h00400013, 32'h00200013, 32'h00002012
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_hi(input int e);
        if (e < 15) return 32'h0;
        if (e == 15) return 32'hFFFF0000;
        return 32'h05050000;
    endfunction

    function automatic logic [31:0] exp_lo(input int e);
        if (e == 18) return 32'h05050000;
        if (e == 19) return 32'hFFFF0000;
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_r4(input int e);
        if (e == 9 || e == 21) return 32'h0;
        if (e == 10 || e == 11) return 32'hFFFF0000;
        return 32'h05050000;
    endfunction

    // Edge e counts rising edges since rst fell; word k commits on edge 6+k.
    task automatic run_prog(input int last);
        for (int e = 1; e <= last; e++) begin
            @(posedge clk); #1;
            if (e == 1) begin
                check("pc_e1", dut.openmips0.pc_q, 32'h0);
                check("ifid_e1", dut.openmips0.if_inst_q, 32'h0);
            end
            if (e == 2) begin
                check("pc_e2", dut.openmips0.pc_q, 32'h4);
                check("ifid_e2", dut.openmips0.if_inst_q, 32'h3C010000);
            end
            if (e == 6) check("r1", dut.openmips0.regfile1.regs[1], 32'h0);
            if (e == 7) check("r2", dut.openmips0.regfile1.regs[2], 32'hFFFF0000);
            if (e == 8) check("r3", dut.openmips0.regfile1.regs[3], 32'h05050000);
            if (e >= 9) check($sformatf("r4_e%0d", e), dut.openmips0.regfile1.regs[4], exp_r4(e));
            check($sformatf("hi_e%0d", e), dut.openmips0.hilo_reg0.hi_o, exp_hi(e));
            check($sformatf("lo_e%0d", e), dut.openmips0.hilo_reg0.lo_o, exp_lo(e));
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) dut.openmips0.inst_rom0.inst_mem[i] = '0;
        for (int i = 0; i < 16; i++) dut.openmips0.inst_rom0.inst_mem[i] = prog[i];

        repeat (10) @(posedge clk);
        #1;
        check("rst_hi", dut.openmips0.hilo_reg0.hi_o, 32'h0);
        check("rst_lo", dut.openmips0.hilo_reg0.lo_o, 32'h0);
        check("rst_pc", dut.openmips0.pc_q, 32'h0);
        #1 rst = 1'b0;

        run_prog(21);

        // Asynchronous assertion between edges must clear HI/LO and PC at once.
        #2 rst = 1'b1;
        #1;
        check("arst_hi", dut.openmips0.hilo_reg0.hi_o, 32'h0);
        check("arst_lo", dut.openmips0.hilo_reg0.lo_o, 32'h0);
        check("arst_pc", dut.openmips0.pc_q, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("arst_r4", dut.openmips0.regfile1.regs[4], 32'h0);
        #1 rst = 1'b0;

        run_prog(11);

        // movn $4,$3,$2 is in flight to WB; reset must squash its write.
        #2 rst = 1'b1;
        #1;
        check("mid_pc", dut.openmips0.pc_q, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_r4", dut.openmips0.regfile1.regs[4], 32'hFFFF0000);
        check("mid_hi", dut.openmips0.hilo_reg0.hi_o, 32'h0);
        check("mid_pc_hold", dut.openmips0.pc_q, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
